// File: rtl/axi_stream_fifo.sv
// First-word-fall-through stream FIFO with fill level, almost-full and flush.
// Data and per-byte user flags are stored together and leave in arrival order.
module axi_stream_fifo #(
  parameter int NUM_DATA_BYTES = 64,
  parameter int DWIDTH         = 512,
  parameter int DEPTH          = 8,
  parameter int AF_THRESH      = 6,
  localparam int LW            = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic                      flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DWIDTH-1:0]         s_data,
  input  logic [NUM_DATA_BYTES-1:0] s_user,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DWIDTH-1:0]         m_data,
  output logic [NUM_DATA_BYTES-1:0] m_user,
  output logic [LW-1:0]             level,
  output logic                      almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DWIDTH + NUM_DATA_BYTES;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("axi_stream_fifo: DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_thresh
    $error("axi_stream_fifo: AF_THRESH must be within 1..DEPTH");
  end

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          af_q, af_d;
  logic          push, pop;

  // Handshakes depend on registered state only, so full blocks a
  // push even when a pop happens in the same cycle.
  assign s_ready = (level_q != LW'(DEPTH)) & ~flush & ~res;
  assign m_valid = (level_q != '0) & ~flush & ~res;

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;

  assign {m_data, m_user} = mem_q[rd_ptr_q];
  assign level            = level_q;
  assign almost_full      = af_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (res | flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    af_d = (level_d >= LW'(AF_THRESH));
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      af_q     <= af_d;
    end
  end

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_data, s_user};
  end

endmodule

// File: doc/axi_stream_fifo.md
Name: axi_stream_fifo

Overview:
- Parametrised, synchronous AXI-stream-style FIFO between a tx-side (slave) and rx-side (master) channel.
- Carries DWIDTH data plus NUM_DATA_BYTES per-byte user flags.
- First-word-fall-through, with fill-level reporting, almost-full flag and synchronous flush.
- Used as the elastic buffer between the link-layer TX/RX paths and the AXI user side.

Parameters:
- NUM_DATA_BYTES, 64, width of the user field (one flag bit per data byte)
- DWIDTH, 512, data width in bits
- DEPTH, 8, number of entries; power of two, >= 2; elaboration fails otherwise
- AF_THRESH, 6, level at or above which almost_full asserts; 1..DEPTH
- LW, $clog2(DEPTH)+1, level width (derived, not overridable)

Ports:
- clk  in  1  clock; all logic rising-edge
- res  in  1  reset, synchronous, active-high
- flush  in  1  synchronous discard of all stored entries
- s_valid  in  1  tx-side valid
- s_ready  out  1  tx-side ready
- s_data  in  DWIDTH  tx-side data
- s_user  in  NUM_DATA_BYTES  tx-side user flags
- m_valid  out  1  rx-side valid
- m_ready  in  1  rx-side ready
- m_data  out  DWIDTH  rx-side data
- m_user  out  NUM_DATA_BYTES  rx-side user flags
- level  out  LW  stored entry count, 0..DEPTH
- almost_full  out  1  registered flag, level >= AF_THRESH

Behaviour:
- Reset (res=1 at a clock edge): wr_ptr, rd_ptr and level go to 0; almost_full=0.
  - s_ready=0 and m_valid=0 while res=1; after reset, s_ready=1 and m_valid=0.
  - m_data/m_user are don't-care while m_valid=0; storage is not cleared.
- Push: s_valid & s_ready at an edge writes {s_data,s_user} to mem[wr_ptr] and increments wr_ptr (wraps DEPTH-1 -> 0).
- Pop: m_valid & m_ready at an edge increments rd_ptr (wraps).
- m_data/m_user = mem[rd_ptr], read combinationally (first-word-fall-through).
- Latency: a word pushed at edge N is presented with m_valid=1 after edge N; minimum 1 cycle. There is no combinational s_* -> m_* path.
- s_ready = (level != DEPTH) & ~flush & ~res.
  - When full, no push is accepted even if a pop occurs in the same cycle; ready depends only on registered state.
- m_valid = (level != 0) & ~flush & ~res.
- Level update:
  - push only: +1
  - pop only: -1
  - push & pop together: unchanged, both pointers advance
  - level never exceeds DEPTH and never underflows.
- almost_full is registered from next-level, so it reflects level in the same cycle level updates; deasserts as soon as level < AF_THRESH.
- Flush (flush=1 at an edge): pointers and level go to 0, almost_full=0. No push or pop occurs that cycle because s_ready and m_valid are held 0. res has priority over flush.
- Mid-packet reset or flush drops stored data. Upstream must treat dropped words as lost; no partial-beat state exists.
- Data ordering is strictly FIFO. The user field travels with its data word unmodified.
- Protocol rules the bench checks:
  - m_valid, once asserted, stays asserted with stable m_data/m_user until popped, except on flush or res.
  - s_ready never asserts while level==DEPTH.

Test Plan:
- Reset with DEPTH=8: after res 1->0, s_ready=1, m_valid=0, level=0, almost_full=0. Pulse res mid-stream at level=5 -> level=0 on the next cycle.
- Fill with m_ready=0: push 8 words 0x1..0x8 -> level 1..8; almost_full=1 from level 6; s_ready=0 at level 8. A 9th s_valid is not accepted and level stays 8.
- Drain: m_ready=1, s_valid=0 -> m_data 0x1..0x8 in order with matching user; level 8..0; almost_full drops at level 5; m_valid=0 after the 8th pop.
- Simultaneous push/pop at level 3 for 20 cycles with incrementing data -> level stays 3, output sequence is contiguous, pointers wrap without gaps.
- Full plus pop: at level 8 assert s_valid & m_ready -> that cycle pops only, level goes 7. The push is accepted in the next cycle and level returns to 8.
- Flush at level 4 with s_valid=1 and m_ready=1 -> no handshake completes that cycle; next cycle level=0, m_valid=0, s_ready=1. A new word 0xAA is the next one output.
